// File: rtl/coef_ram_arbiter.sv
// Round-robin arbiter sharing one single-port coefficient RAM between two lowpass filters,
// with a host load mode. Optional stall counters: define COEF_ARB_STATS_EN.
module coef_ram_arbiter #(
  parameter int AW     = 7,
  parameter int DW     = 18,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_gnt,
  output logic [DW-1:0] r_data,
  output logic          r_valid,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  output logic          l_gnt,
  output logic [DW-1:0] l_data,
  output logic          l_valid,
  input  logic          host_load,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef COEF_ARB_STATS_EN
  ,
  output logic [15:0]   r_stall_cnt,
  output logic [15:0]   l_stall_cnt
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic CLIENT_R = 1'b0;
  localparam logic CLIENT_L = 1'b1;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              last_reg;
  logic [RD_LAT-1:0] tag_valid_reg;
  logic [RD_LAT-1:0] tag_client_reg;
  logic              grant_ok;
  logic              pipe_empty;
  logic              load_entry;
  logic              in_load;
  logic [1:0]        req_vec;
  logic [1:0]        gnt_vec;
  logic [1:0]        valid_bus;
  logic [DW-1:0]     data_bus [2];

  assign pipe_empty = ~|tag_valid_reg;
  assign in_load    = !reset && (state_reg == ST_LOAD);
  assign host_ready = in_load;
  assign load_entry = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
  assign req_vec    = {l_req, r_req};
  assign gnt_vec    = {l_gnt, r_gnt};

  // Grants are suppressed the same cycle host_load is first seen.
  assign grant_ok = !reset && (state_reg == ST_RUN) && !host_load;

  always_comb begin
    r_gnt = 1'b0;
    l_gnt = 1'b0;
    if (grant_ok) begin
      if (r_req && (!l_req || last_reg == CLIENT_L)) begin
        r_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (host_load) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!host_load) begin
          state_next = ST_RUN;
        end else if (pipe_empty) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!host_load) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
      last_reg  <= CLIENT_L;
    end else begin
      state_reg <= state_next;
      if (r_gnt) begin
        last_reg <= CLIENT_R;
      end else if (l_gnt) begin
        last_reg <= CLIENT_L;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (in_load) begin
      ram_addr  = host_addr;
      ram_we    = host_we;
      ram_wdata = host_wdata;
    end else if (r_gnt) begin
      ram_addr = r_addr;
    end else if (l_gnt) begin
      ram_addr = l_addr;
    end
  end

  // Tag pipe tracks which client owns the read data arriving RD_LAT cycles later.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid_reg  <= '0;
      tag_client_reg <= '0;
    end else begin
      tag_valid_reg[0]  <= r_gnt | l_gnt;
      tag_client_reg[0] <= l_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid_reg[i]  <= tag_valid_reg[i-1];
        tag_client_reg[i] <= tag_client_reg[i-1];
      end
    end
  end

`ifdef COEF_ARB_STATS_EN
  logic [15:0] stall_bus [2];
  assign r_stall_cnt = stall_bus[0];
  assign l_stall_cnt = stall_bus[1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      localparam logic CLIENT_ID = (gi == 1);
      logic          valid_reg;
      logic [DW-1:0] data_reg;
      logic          capture;

      assign capture = tag_valid_reg[RD_LAT-1] && (tag_client_reg[RD_LAT-1] == CLIENT_ID);

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= capture;
          if (capture) begin
            data_reg <= ram_rdata;
          end
        end
      end

      assign valid_bus[gi] = valid_reg;
      assign data_bus[gi]  = data_reg;

`ifdef COEF_ARB_STATS_EN
      logic [15:0] stall_cnt_reg;
      always_ff @(posedge clock) begin
        if (reset || load_entry) begin
          stall_cnt_reg <= '0;
        end else if (req_vec[gi] && !gnt_vec[gi] && stall_cnt_reg != 16'hFFFF) begin
          stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
      end
      assign stall_bus[gi] = stall_cnt_reg;
`endif
    end
  endgenerate

  assign r_valid = valid_bus[0];
  assign l_valid = valid_bus[1];
  assign r_data  = data_bus[0];
  assign l_data  = data_bus[1];

`ifndef COEF_ARB_STATS_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, load_entry, req_vec, gnt_vec};
`endif

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Directed bench for coef_ram_arbiter with a 128x18 single-port RAM model (read latency 1).
module tb_coef_ram_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r_req = 1'b0, l_req = 1'b0;
  logic [6:0]  r_addr = '0, l_addr = '0;
  logic        r_gnt, l_gnt, r_valid, l_valid;
  logic [17:0] r_data, l_data;
  logic        host_load = 1'b0, host_we = 1'b0, host_ready;
  logic [6:0]  host_addr = '0;
  logic [17:0] host_wdata = '0;
  logic [6:0]  ram_addr;
  logic        ram_we;
  logic [17:0] ram_wdata;
  logic [17:0] ram_rdata = '0;
`ifdef COEF_ARB_STATS_EN
  logic [15:0] r_stall_cnt, l_stall_cnt;
`endif

  logic [17:0] mem [128];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  coef_ram_arbiter dut (
    .clock(clock), .reset(reset),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_data(r_data), .r_valid(r_valid),
    .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt), .l_data(l_data), .l_valid(l_valid),
    .host_load(host_load), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef COEF_ARB_STATS_EN
    , .r_stall_cnt(r_stall_cnt), .l_stall_cnt(l_stall_cnt)
`endif
  );

  function automatic logic [17:0] f(int i);
    logic [31:0] t;
    t = i * 291 + 165;
    return t[17:0] ^ 18'h2AAAA;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    r_req = 0; l_req = 0; host_load = 0; host_we = 0;
    r_addr = '0; l_addr = '0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic do_reset();
    cyc(); reset = 1; idle_inputs();
    cyc(); cyc(); reset = 0;
  endtask

  typedef struct {
    logic       rq, lq, hl;
    logic [6:0] ra, la;
    logic       eg_r, eg_l;
    logic [6:0] e_addr;
    logic       e_rv, e_lv;
    logic [6:0] e_daddr;
  } vec_t;

  function automatic vec_t mk(int rq, int ra, int lq, int la, int hl,
                              int egr, int egl, int ea, int erv, int elv, int eda);
    vec_t v;
    v.rq = 1'(rq); v.ra = 7'(ra); v.lq = 1'(lq); v.la = 7'(la); v.hl = 1'(hl);
    v.eg_r = 1'(egr); v.eg_l = 1'(egl); v.e_addr = 7'(ea);
    v.e_rv = 1'(erv); v.e_lv = 1'(elv); v.e_daddr = 7'(eda);
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = f(i);

    //          rq ra lq la hl  gR gL addr rv lv daddr
    tbl[0] = mk(1, 3, 1, 9, 0,  1, 0, 3,   0, 0, 0);
    tbl[1] = mk(1, 4, 1, 9, 0,  0, 1, 9,   0, 0, 0);
    tbl[2] = mk(0, 0, 1, 10, 0, 0, 1, 10,  1, 0, 3);
    tbl[3] = mk(1, 4, 1, 11, 0, 1, 0, 4,   0, 1, 9);
    tbl[4] = mk(0, 0, 0, 0, 0,  0, 0, 0,   0, 1, 10);
    tbl[5] = mk(0, 0, 1, 12, 0, 0, 1, 12,  1, 0, 4);
    tbl[6] = mk(1, 5, 0, 0, 0,  1, 0, 5,   0, 0, 0);
    tbl[7] = mk(1, 6, 1, 13, 0, 0, 1, 13,  0, 1, 12);
    tbl[8] = mk(1, 6, 1, 13, 1, 0, 0, 0,   1, 0, 5);
    tbl[9] = mk(0, 0, 0, 0, 1,  0, 0, 0,   0, 1, 13);

    // Reset state, with requests and a host write strobe asserted during reset.
    cyc(); r_req = 1; l_req = 1; host_we = 1; host_addr = 7'd3; #3;
    chk("rst_r_gnt", 32'(r_gnt), 0);
    chk("rst_l_gnt", 32'(l_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    cyc(); cyc(); reset = 0; idle_inputs(); #3;
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_l_valid", 32'(l_valid), 0);
    chk("rst_r_data", 32'(r_data), 0);
    chk("rst_l_data", 32'(l_data), 0);
    chk("rst_host_ready", 32'(host_ready), 0);

    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc();
      r_req = tbl[k].rq; r_addr = tbl[k].ra; l_req = tbl[k].lq; l_addr = tbl[k].la;
      host_load = tbl[k].hl;
      #3;
      chk($sformatf("tbl%0d_r_gnt", k), 32'(r_gnt), 32'(tbl[k].eg_r));
      chk($sformatf("tbl%0d_l_gnt", k), 32'(l_gnt), 32'(tbl[k].eg_l));
      chk($sformatf("tbl%0d_ram_addr", k), 32'(ram_addr), 32'(tbl[k].e_addr));
      chk($sformatf("tbl%0d_r_valid", k), 32'(r_valid), 32'(tbl[k].e_rv));
      chk($sformatf("tbl%0d_l_valid", k), 32'(l_valid), 32'(tbl[k].e_lv));
      if (tbl[k].e_rv) chk($sformatf("tbl%0d_r_data", k), 32'(r_data), 32'(f(int'(tbl[k].e_daddr))));
      if (tbl[k].e_lv) chk($sformatf("tbl%0d_l_data", k), 32'(l_data), 32'(f(int'(tbl[k].e_daddr))));
      $display("vec %0d: r_gnt=%0b l_gnt=%0b ram_addr=%0d r_valid=%0b l_valid=%0b",
               k, r_gnt, l_gnt, ram_addr, r_valid, l_valid);
    end

    // Right-only back-to-back sweep over every address.
    do_reset();
    for (int i = 0; i < 130; i++) begin
      cyc();
      r_req = (i < 128); r_addr = 7'(i);
      #3;
      if (i < 128) chk($sformatf("sweep%0d_r_gnt", i), 32'(r_gnt), 1);
      chk($sformatf("sweep%0d_r_valid", i), 32'(r_valid), (i >= 2) ? 1 : 0);
      if (i >= 2) chk($sformatf("sweep%0d_r_data", i), 32'(r_data), 32'(f(i - 2)));
      chk($sformatf("sweep%0d_l_valid", i), 32'(l_valid), 0);
    end
    $display("sweep: 128 right reads issued");

    // Host write strobe outside LOAD is dropped.
    do_reset();
    cyc(); host_we = 1; host_addr = 7'd7; host_wdata = 18'h3FFFF; r_req = 1; r_addr = 7'd7; #3;
    chk("hwe_ram_we_a", 32'(ram_we), 0);
    chk("hwe_r_gnt", 32'(r_gnt), 1);
    chk("hwe_ram_addr", 32'(ram_addr), 7);
    cyc(); r_req = 0; #3;
    chk("hwe_ram_we_b", 32'(ram_we), 0);
    chk("hwe_ram_addr_idle", 32'(ram_addr), 0);
    cyc(); host_we = 0; #3;
    chk("hwe_r_data_a", 32'(r_data), 32'(f(7)));
    cyc(); r_req = 1; r_addr = 7'd7; #3;
    cyc(); r_req = 0; #3;
    cyc(); #3;
    chk("hwe_r_valid", 32'(r_valid), 1);
    chk("hwe_r_data_b", 32'(r_data), 32'(f(7)));
    $display("host_we ignored outside LOAD: r_data=%0h", r_data);

    // Drain with reads in flight, load address 5, read it back.
    do_reset();
    cyc(); r_req = 1; r_addr = 7'd1; #3;
    chk("drn_c0_r_gnt", 32'(r_gnt), 1);
    cyc(); r_req = 0; l_req = 1; l_addr = 7'd2; #3;
    chk("drn_c1_l_gnt", 32'(l_gnt), 1);
    cyc(); l_req = 0; host_load = 1; #3;
    chk("drn_c2_r_valid", 32'(r_valid), 1);
    chk("drn_c2_r_data", 32'(r_data), 32'(f(1)));
    chk("drn_c2_ready", 32'(host_ready), 0);
    cyc(); r_req = 1; r_addr = 7'd5; #3;
    chk("drn_c3_r_gnt", 32'(r_gnt), 0);
    chk("drn_c3_l_valid", 32'(l_valid), 1);
    chk("drn_c3_l_data", 32'(l_data), 32'(f(2)));
    chk("drn_c3_ready", 32'(host_ready), 0);
    cyc(); host_we = 1; host_addr = 7'd5; host_wdata = 18'h1ABCD; #3;
    chk("ld_c4_ready", 32'(host_ready), 1);
    chk("ld_c4_ram_we", 32'(ram_we), 1);
    chk("ld_c4_ram_addr", 32'(ram_addr), 5);
    chk("ld_c4_ram_wdata", 32'(ram_wdata), 32'h1ABCD);
    chk("ld_c4_r_gnt", 32'(r_gnt), 0);
    cyc(); host_we = 0; host_load = 0; #3;
    chk("ld_c5_ready", 32'(host_ready), 1);
    chk("ld_c5_r_gnt", 32'(r_gnt), 0);
    cyc(); #3;
    chk("ld_c6_ready", 32'(host_ready), 0);
    chk("ld_c6_r_gnt", 32'(r_gnt), 1);
    chk("ld_c6_ram_addr", 32'(ram_addr), 5);
    cyc(); r_req = 0; #3;
    cyc(); #3;
    chk("ld_c8_r_valid", 32'(r_valid), 1);
    chk("ld_c8_r_data", 32'(r_data), 32'h1ABCD);
    $display("load: addr 5 read back %0h", r_data);

    // Reset one cycle after a grant discards the read.
    cyc(); r_req = 1; r_addr = 7'd9; #3;
    chk("rmid_c0_r_gnt", 32'(r_gnt), 1);
    cyc(); reset = 1; l_req = 1; #3;
    chk("rmid_c1_r_gnt", 32'(r_gnt), 0);
    chk("rmid_c1_l_gnt", 32'(l_gnt), 0);
    chk("rmid_c1_ram_addr", 32'(ram_addr), 0);
    cyc(); reset = 0; idle_inputs(); #3;
    chk("rmid_c2_r_valid", 32'(r_valid), 0);
    chk("rmid_c2_r_data", 32'(r_data), 0);
    cyc(); #3;
    chk("rmid_c3_r_valid", 32'(r_valid), 0);
    chk("rmid_c3_l_valid", 32'(l_valid), 0);
    chk("rmid_c3_ready", 32'(host_ready), 0);
    $display("reset mid-read: r_valid=%0b r_data=%0h", r_valid, r_data);

`ifdef COEF_ARB_STATS_EN
    do_reset();
    cyc(); host_load = 1; #3;
    cyc(); #3;
    for (int i = 0; i < 10; i++) begin
      cyc(); l_req = 1; l_addr = 7'd4; #3;
      if (i == 0) chk("st_ready", 32'(host_ready), 1);
    end
    cyc(); l_req = 0; host_load = 0; #3;
    chk("st_l_stall", 32'(l_stall_cnt), 10);
    chk("st_r_stall", 32'(r_stall_cnt), 0);
    cyc(); host_load = 1; #3;
    cyc(); #3;
    cyc(); #3;
    chk("st_clear_ready", 32'(host_ready), 1);
    chk("st_l_stall_clr", 32'(l_stall_cnt), 0);
    $display("stats: l_stall_cnt=%0d after reentry", l_stall_cnt);
    cyc(); idle_inputs();
`endif

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
